// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: result request record and winner tags.
package wb_pkg;

   localparam int REG_IDX_W = 5;
   localparam int WB_XLEN   = 32;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU,
      WB_CSR
   } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Decode query, execute-unit result channels and regfile write port of the writeback arbiter.
interface wb_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) ();
   import wb_pkg::*;

   logic                 issue_valid;
   logic [REG_IDX_W-1:0] issue_rd;
   logic [REG_IDX_W-1:0] chk_rs1;
   logic [REG_IDX_W-1:0] chk_rs2;
   logic [REG_IDX_W-1:0] chk_rd;
   logic                 hz_rs1;
   logic                 hz_rs2;
   logic                 hz_rd;

   logic                 alu_valid;
   logic [REG_IDX_W-1:0] alu_rd;
   logic [XLEN-1:0]      alu_data;

   logic                 lsu_valid;
   logic                 lsu_ready;
   logic [REG_IDX_W-1:0] lsu_rd;
   logic [XLEN-1:0]      lsu_data;

   logic                 csr_valid;
   logic                 csr_ready;
   logic [REG_IDX_W-1:0] csr_rd;
   logic [XLEN-1:0]      csr_data;

   logic                 wr;
   logic [REG_IDX_W-1:0] rd;
   logic [XLEN-1:0]      rd_d;
   logic [NREGS-1:0]     busy;

   modport slave (
      input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  csr_valid, csr_rd, csr_data,
      output hz_rs1, hz_rs2, hz_rd, lsu_ready, csr_ready,
      output wr, rd, rd_d, busy
   );

   modport master (
      output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output csr_valid, csr_rd, csr_data,
      input  hz_rs1, hz_rs2, hz_rd, lsu_ready, csr_ready,
      input  wr, rd, rd_d, busy
   );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; buffers load results until the regfile port is free.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output wb_req_t head
);

   localparam int AW = $clog2(DEPTH);

   wb_req_t       mem_q [DEPTH];
   wb_req_t       mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full)) else $error("wb_fifo: push while full");
         assert (!(pop && empty)) else $error("wb_fifo: pop while empty");
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU, load and CSR results onto the single regfile write port and tracks
// in-flight destinations in a busy scoreboard for decode hazard checks.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NREGS          = 32,
   parameter int LSU_FIFO_DEPTH = 2
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   wb_req_t              fifo_head, lsu_req, win;
   wb_src_e              win_src;
   logic                 wr_q, wr_d;
   logic [REG_IDX_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]      data_q, data_d;
   logic [NREGS-1:0]     busy_q, busy_d;

   assign lsu_req = '{valid: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data};

   wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_lsu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (lsu_req),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Fixed priority ALU > buffered load > CSR; nothing wins while in reset.
   always_comb begin
      win_src = WB_NONE;
      if (!rst) begin
         if (bus.alu_valid)      win_src = WB_ALU;
         else if (!fifo_empty)   win_src = WB_LSU;
         else if (bus.csr_valid) win_src = WB_CSR;
      end
   end

   always_comb begin
      win = '0;
      case (win_src)
         WB_ALU:  win = '{valid: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
         WB_LSU:  win = fifo_head;
         WB_CSR:  win = '{valid: 1'b1, rd: bus.csr_rd, data: bus.csr_data};
         default: win = '0;
      endcase
   end

   assign fifo_pop      = (win_src == WB_LSU);
   assign bus.lsu_ready = !rst && !fifo_full;
   assign bus.csr_ready = (win_src == WB_CSR);
   assign fifo_push     = bus.lsu_valid && bus.lsu_ready;

   // Writes to x0 are consumed but never reach the regfile; set beats clear on the same index.
   always_comb begin
      wr_d   = win.valid && (win.rd != '0);
      rd_d   = rd_q;
      data_d = data_q;
      if (wr_d) begin
         rd_d   = win.rd;
         data_d = win.data;
      end
      busy_d = busy_q;
      if (wr_q) busy_d[rd_q] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign bus.wr     = wr_q;
   assign bus.rd     = rd_q;
   assign bus.rd_d   = data_q;
   assign bus.busy   = busy_q;
   assign bus.hz_rs1 = busy_q[bus.chk_rs1] && (bus.chk_rs1 != '0);
   assign bus.hz_rs2 = busy_q[bus.chk_rs2] && (bus.chk_rs2 != '0);
   assign bus.hz_rd  = busy_q[bus.chk_rd]  && (bus.chk_rd  != '0);

   // Every accepted non-x0 result must belong to an instruction decode already marked in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (bus.alu_valid && (bus.alu_rd != '0))
            assert (busy_q[bus.alu_rd]) else $error("wb_arbiter: ALU result to idle x%0d", bus.alu_rd);
         if (fifo_push && (bus.lsu_rd != '0))
            assert (busy_q[bus.lsu_rd]) else $error("wb_arbiter: load result to idle x%0d", bus.lsu_rd);
         if (bus.csr_valid && bus.csr_ready && (bus.csr_rd != '0))
            assert (busy_q[bus.csr_rd]) else $error("wb_arbiter: CSR result to idle x%0d", bus.csr_rd);
         assert (!(bus.alu_valid && bus.issue_valid && (bus.alu_rd == bus.issue_rd) && (bus.alu_rd != '0)))
            else $error("wb_arbiter: ALU result and issue on same x%0d", bus.alu_rd);
         assert (!(bus.lsu_valid && bus.lsu_ready && fifo_full))
            else $error("wb_arbiter: load push while FIFO full");
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, single writeback, collision, FIFO full, x0 and mid-drain reset.
module tb_wb_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   wb_arbiter_if #(.XLEN(32), .NREGS(32)) bus ();

   wb_arbiter #(.XLEN(32), .NREGS(32), .LSU_FIFO_DEPTH(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle's worth of inputs, then lets the combinational outputs settle.
   task automatic applyStimulus(
      input logic        iv,  input logic [4:0] ird,
      input logic        av,  input logic [4:0] ard, input logic [31:0] ad,
      input logic        lv,  input logic [4:0] lrd, input logic [31:0] ld,
      input logic        cv,  input logic [4:0] crd, input logic [31:0] cd
   );
      bus.issue_valid = iv;
      bus.issue_rd    = ird;
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_data    = ad;
      bus.lsu_valid   = lv;
      bus.lsu_rd      = lrd;
      bus.lsu_data    = ld;
      bus.csr_valid   = cv;
      bus.csr_rd      = crd;
      bus.csr_data    = cd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.chk_rs1 = 5'd0;
      bus.chk_rs2 = 5'd0;
      bus.chk_rd  = 5'd0;
      applyStimulus(0, 0, 0, 0, 0, 1, 5'd1, 32'h1, 1, 5'd0, 32'h0);
      repeat (3) tick();
      checkOutput("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
      checkOutput("rst_csr_ready", 32'(bus.csr_ready), 32'd0);
      checkOutput("rst_wr", 32'(bus.wr), 32'd0);
      checkOutput("rst_busy", bus.busy, 32'h0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
      checkOutput("post_rst_csr_ready", 32'(bus.csr_ready), 32'd0);

      // Single ALU writeback to x5
      bus.chk_rs1 = 5'd5;
      tick(); applyStimulus(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("alu_hz_before", 32'(bus.hz_rs1), 32'd0);
      tick(); applyStimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      checkOutput("alu_hz_issued", 32'(bus.hz_rs1), 32'd1);
      checkOutput("alu_wr_early", 32'(bus.wr), 32'd0);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("alu_wr", 32'(bus.wr), 32'd1);
      checkOutput("alu_rd", 32'(bus.rd), 32'd5);
      checkOutput("alu_data", bus.rd_d, 32'hDEADBEEF);
      checkOutput("alu_hz_during_wr", 32'(bus.hz_rs1), 32'd1);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("alu_wr_done", 32'(bus.wr), 32'd0);
      checkOutput("alu_hz_after", 32'(bus.hz_rs1), 32'd0);
      checkOutput("alu_rd_hold", 32'(bus.rd), 32'd5);
      checkOutput("alu_busy_after", bus.busy, 32'h0);
      bus.chk_rs1 = 5'd0;

      // Three-way collision on x1/x2/x3
      tick(); applyStimulus(1, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(1, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 5'd3, 32'h33);
      checkOutput("col_csr_ready_0", 32'(bus.csr_ready), 32'd0);
      checkOutput("col_lsu_ready", 32'(bus.lsu_ready), 32'd1);
      checkOutput("col_busy_start", bus.busy, 32'h0000000E);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33);
      checkOutput("col_csr_ready_1", 32'(bus.csr_ready), 32'd0);
      checkOutput("col_wr1", 32'(bus.wr), 32'd1);
      checkOutput("col_rd1", 32'(bus.rd), 32'd1);
      checkOutput("col_data1", bus.rd_d, 32'h11);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33);
      checkOutput("col_csr_ready_2", 32'(bus.csr_ready), 32'd1);
      checkOutput("col_wr2", 32'(bus.wr), 32'd1);
      checkOutput("col_rd2", 32'(bus.rd), 32'd2);
      checkOutput("col_data2", bus.rd_d, 32'h22);
      checkOutput("col_busy_mid", bus.busy, 32'h0000000C);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("col_wr3", 32'(bus.wr), 32'd1);
      checkOutput("col_rd3", 32'(bus.rd), 32'd3);
      checkOutput("col_data3", bus.rd_d, 32'h33);
      checkOutput("col_busy_late", bus.busy, 32'h00000008);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("col_wr_done", 32'(bus.wr), 32'd0);
      checkOutput("col_busy_end", bus.busy, 32'h0);

      // FIFO fills while the ALU (writing x0) hogs the port
      tick(); applyStimulus(1, 5'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(1, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'hAA, 1, 5'd4, 32'h44, 0, 0, 0);
      checkOutput("full_ready_p0", 32'(bus.lsu_ready), 32'd1);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'hAA, 1, 5'd5, 32'h55, 0, 0, 0);
      checkOutput("full_ready_p1", 32'(bus.lsu_ready), 32'd1);
      checkOutput("full_wr_p1", 32'(bus.wr), 32'd0);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'hAA, 1, 5'd6, 32'h66, 0, 0, 0);
      checkOutput("full_ready_p2", 32'(bus.lsu_ready), 32'd0);
      checkOutput("full_wr_p2", 32'(bus.wr), 32'd0);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'hAA, 1, 5'd6, 32'h66, 0, 0, 0);
      checkOutput("full_ready_p3", 32'(bus.lsu_ready), 32'd0);
      checkOutput("full_busy_p3", bus.busy, 32'h00000070);
      tick(); applyStimulus(0, 0, 0, 0, 0, 1, 5'd6, 32'h66, 0, 0, 0);
      checkOutput("full_ready_p4", 32'(bus.lsu_ready), 32'd0);
      checkOutput("full_wr_p4", 32'(bus.wr), 32'd0);
      tick(); applyStimulus(0, 0, 0, 0, 0, 1, 5'd6, 32'h66, 0, 0, 0);
      checkOutput("full_ready_p5", 32'(bus.lsu_ready), 32'd1);
      checkOutput("drain_rd4", 32'(bus.rd), 32'd4);
      checkOutput("drain_data4", bus.rd_d, 32'h44);
      checkOutput("drain_wr4", 32'(bus.wr), 32'd1);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("drain_rd5", 32'(bus.rd), 32'd5);
      checkOutput("drain_data5", bus.rd_d, 32'h55);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("drain_rd6", 32'(bus.rd), 32'd6);
      checkOutput("drain_data6", bus.rd_d, 32'h66);
      checkOutput("drain_wr6", 32'(bus.wr), 32'd1);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("drain_wr_done", 32'(bus.wr), 32'd0);
      checkOutput("drain_busy_end", bus.busy, 32'h0);

      // CSR result to x0 is accepted but never written
      tick(); applyStimulus(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      checkOutput("x0_csr_ready", 32'(bus.csr_ready), 32'd1);
      checkOutput("x0_busy_before", bus.busy, 32'h00000200);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_wr", 32'(bus.wr), 32'd0);
      checkOutput("x0_busy_after", bus.busy, 32'h00000200);

      // Reset while two loads wait in the FIFO
      tick(); applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'h0, 1, 5'd7, 32'h77, 0, 0, 0);
      tick(); applyStimulus(0, 0, 1, 5'd0, 32'h0, 1, 5'd8, 32'h88, 0, 0, 0);
      checkOutput("mid_ready_one", 32'(bus.lsu_ready), 32'd1);
      tick();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_ready_in_rst", 32'(bus.lsu_ready), 32'd0);
      checkOutput("mid_busy_pre", bus.busy, 32'h00000380);
      tick();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_wr_after", 32'(bus.wr), 32'd0);
      checkOutput("mid_busy_after", bus.busy, 32'h0);
      checkOutput("mid_ready_after", 32'(bus.lsu_ready), 32'd1);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h0);
      checkOutput("mid_wr_later", 32'(bus.wr), 32'd0);
      checkOutput("mid_fifo_empty", 32'(bus.csr_ready), 32'd1);
      tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_wr_final", 32'(bus.wr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer-side companion to the register file. Merges ALU, load/store and CSR results onto the single regfile write port (wr/rd/rd_d).
- Keeps a per-register busy scoreboard so decode can detect RAW/WAW hazards against in-flight writebacks.
- Sits between the execute units and the regfile. Decode queries it before issue.

Parameters:
XLEN, 32, data width of results and regfile write data
NREGS, 32, number of architectural registers (index width = $clog2(NREGS))
LSU_FIFO_DEPTH, 2, entries in the load-result buffer (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  5  destination of the issued instruction
chk_rs1  in  5  decode source-1 query
chk_rs2  in  5  decode source-2 query
chk_rd  in  5  decode destination query
hz_rs1  out  1  chk_rs1 busy (combinational)
hz_rs2  out  1  chk_rs2 busy (combinational)
hz_rd  out  1  chk_rd busy (combinational)
alu_valid  in  1  ALU result present; never back-pressured
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load result offered
lsu_ready  out  1  load FIFO can accept
lsu_rd  in  5  load destination
lsu_data  in  XLEN  load result
csr_valid  in  1  CSR result offered
csr_ready  out  1  CSR result accepted this cycle
csr_rd  in  5  CSR destination
csr_data  in  XLEN  CSR read value
wr  out  1  regfile write enable (registered)
rd  out  5  regfile write index (registered)
rd_d  out  XLEN  regfile write data (registered)
busy  out  NREGS  scoreboard vector (registered)

Behaviour:
- Reset:
  - wr=0, rd=0, rd_d=0, busy=0, FIFO empty.
  - lsu_ready=0 and csr_ready=0 while rst is high. lsu_ready=1 in the first cycle after reset.
- Handshakes:
  - LSU: transfer occurs when lsu_valid && lsu_ready. lsu_ready = !fifo_full. Every load result goes through the FIFO; there is no bypass.
  - CSR: transfer occurs when csr_valid && csr_ready. csr_ready is combinational and high only when the CSR wins arbitration.
- Arbitration, evaluated each cycle:
  - Priority is ALU > FIFO head > CSR.
  - The winner is registered onto wr/rd/rd_d at the next edge: 1-cycle latency for ALU and CSR, at least 2 cycles for LSU.
  - A FIFO pop occurs only when the FIFO wins.
  - With no winner, wr=0 and rd/rd_d hold their previous values.
- x0 handling:
  - A result with rd==0 is consumed normally (handshake, pop) but produces wr=0.
  - issue_rd==0 never sets busy. hz_* for index 0 is always 0.
- Scoreboard:
  - busy[issue_rd] is set at the edge where issue_valid=1.
  - busy[rd] is cleared at the edge ending the cycle in which wr=1. The register therefore reads as not busy exactly when the regfile write has committed, which is required because the regfile reads are synchronous with no write-through.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- hz_x = busy[chk_x], purely combinational from registered busy.
- Decode guarantees no issue while hz_rd=1 (no WAW). Sim-only assertions:
  - a result targets a non-busy register;
  - alu_valid && issue_valid target the same non-zero rd;
  - an LSU push occurs when full.
- FIFO:
  - Pointers wrap modulo LSU_FIFO_DEPTH.
  - Simultaneous push and pop when full is not allowed: lsu_ready=0, so no push happens.
  - Simultaneous push and pop when empty is impossible because there is no bypass.
- rst mid-operation flushes the FIFO and busy, and drops any pending winner. wr is 0 in the cycle after the rst edge.

Decomposition:
- Shared package wb_pkg holds:
  - wb_req_t struct {valid, rd[4:0], data[XLEN-1:0]};
  - localparam REG_IDX_W = 5;
  - enum wb_src_e {WB_NONE, WB_ALU, WB_LSU, WB_CSR} for debug/trace.
- One sub-module, wb_fifo: a parameterized sync FIFO of wb_req_t with push/pop/full/empty/head.
- Arbiter and scoreboard stay in the top.

Test Plan:
- Reset: hold rst 3 cycles with lsu_valid=1 → lsu_ready=0, wr=0, busy=0. Release → lsu_ready=1.
- Single ALU writeback:
  - Stimulus: issue x5; next cycle alu_valid with rd=5, data=0xDEADBEEF.
  - Required response: the following cycle wr=1, rd=5, rd_d=0xDEADBEEF; hz_rs1(chk_rs1=5)=1 through that cycle, then 0.
- Three-way collision:
  - Stimulus: issue x1, x2, x3; then in the same cycle alu_valid (rd=1, 0x11), lsu_valid (rd=2, 0x22), csr_valid (rd=3, 0x33).
  - Required response: csr_ready=0 that cycle; writes appear as x1, x2, x3 on consecutive cycles with the matching data; busy ends at 0.
- FIFO full:
  - Stimulus: alu_valid held high continuously while 3 loads (x4, x5, x6) are offered.
  - Required response: lsu_ready drops after 2 pushes; on ALU release the loads drain in order 4, 5, 6.
- x0 discard: csr_valid with rd=0, data=0xFFFFFFFF → csr_ready=1, wr stays 0, busy unchanged.
- Reset mid-drain: 2 loads in the FIFO, assert rst for 1 cycle → no further wr, busy=0, FIFO empty, lsu_ready=1.
